tx_serializer: RTL and testbench
================================

# tx_serializer

Transmit-side parallel-to-serial framer that feeds the H-bridge output driver stage. It accepts one WIDTH-bit word per frame over a valid/ready handshake, then emits a serial frame: preamble, data LSB-first, even parity. It also produces the leg-select and serial bit consumed by the driver. `ser_bit` wires to both driver data inputs and `ser_sel` wires to the driver select, so the select never changes while a frame is on the line.

## Interface
- `WIDTH`, default 8: data word width, ≥ 2.
- `PRE_LEN`, default 4: preamble length in bits, ≥ 1.
- `PRE_PATTERN`, default 4'b0101: preamble bits, sent LSB-first.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bit_en` in 1: bit-rate strobe; one-cycle pulse per serial bit period.
- `tx_data` in WIDTH: word to send.
- `tx_lane` in 1: output leg for the frame (0 = driver leg 1, 1 = driver leg 2).
- `tx_valid` in 1: `tx_data` and `tx_lane` are valid.
- `tx_ready` out 1: block can accept a word.
- `ser_bit` out 1: registered serial bit to the driver.
- `ser_sel` out 1: registered leg select to the driver.
- `ser_active` out 1: high while a frame bit is on `ser_bit`.

## Operation
- Frame length is N = PRE_LEN + WIDTH + 1 bits, in this order:
  - PRE_PATTERN[0..PRE_LEN-1];
  - tx_data[0..WIDTH-1];
  - parity = XOR of all data bits (even parity).
- States:
  - IDLE: `tx_ready` = 1.
  - SEND: `tx_ready` = 0.
- `tx_ready` is combinational: (state == IDLE) && !rst.
- IDLE → SEND on a clock edge with tx_valid && tx_ready. At that edge:
  - latch data into the shift register;
  - latch `tx_lane` into `ser_sel`;
  - compute parity;
  - set bit index = 0, `ser_bit` = frame bit 0, `ser_active` = 1.
- Acceptance does not wait for `bit_en`.
- In SEND, each edge with `bit_en` = 1 advances the bit index and loads the next frame bit into `ser_bit`. Edges with `bit_en` = 0 hold all outputs.
- SEND → IDLE on the `bit_en` edge while the bit index is N-1. At that edge `ser_bit` ← 0 and `ser_active` ← 0.
- `ser_sel` holds its last value in IDLE. It changes only at acceptance.
- `tx_valid`, `tx_data` and `tx_lane` are ignored in SEND. A change of `tx_lane` mid-frame has no effect.
- Bit index counter width is $clog2(N); it never exceeds N-1.
- Idle line: `ser_bit` = 0, so both driver outputs are 0.

## Timing
- Reset values (the edge with `rst` = 1): state IDLE, `ser_bit` 0, `ser_sel` 0, `ser_active` 0, bit index 0, shift register 0.
- `tx_ready` = 0 while `rst` is high and 1 in the first cycle after deassertion.
- Reset mid-frame aborts the frame immediately: outputs are at reset values on the next cycle and the partial word is discarded.
- `rst` dominates a simultaneous `tx_valid` and `bit_en`.
- Latency: the first frame bit appears on `ser_bit` in the cycle after the accepting edge.
- With `bit_en` tied high, a frame occupies exactly N cycles of `ser_active`, followed by at least one IDLE cycle before the next accept.
- Minimum frame-to-frame spacing is N+1 cycles (`bit_en` = 1).
- A `bit_en` pulse on the accepting edge does not advance the frame. Bit 0 is held until the next `bit_en`.
- `tx_valid` may be held high across frames. The next word is accepted on the first IDLE edge.
- All outputs are registered except `tx_ready`. No combinational path from inputs to `ser_*`.

## Test plan
All scenarios use defaults: WIDTH = 8, PRE_LEN = 4, PRE_PATTERN = 4'b0101, N = 13.
- Basic frame: `bit_en` = 1, tx_data = 0x3C, lane 0.
  - Required: `ser_bit` = 1,0,1,0, 0,0,1,1,1,1,0,0, 0 over 13 cycles.
  - `ser_sel` = 0, `ser_active` high 13 cycles, then `ser_bit` = 0 and `tx_ready` = 1.
- Odd parity data: tx_data = 0x01, lane 1.
  - Required: parity bit = 1 and `ser_sel` = 1 throughout.
  - `ser_sel` stays 1 after the frame ends.
- Baud strobe: `bit_en` every 4th cycle, tx_data = 0xA5.
  - Required: each bit held exactly 4 cycles (bit 0 held until the first strobe after accept).
  - Frame ends on the 13th strobe.
- Back-to-back: `tx_valid` held high with words 0x55 then 0xAA, `bit_en` = 1.
  - Required: second accept occurs exactly 14 cycles after the first.
  - `tx_ready` low during each SEND; `tx_lane` toggled mid-frame does not alter `ser_sel`.
- Reset mid-frame: assert `rst` for 1 cycle at bit index 6 of a frame.
  - Required: next cycle `ser_bit` = 0, `ser_sel` = 0, `ser_active` = 0.
  - `tx_ready` = 1 the cycle after `rst` drops; a new frame starts cleanly with the preamble.
- Reset priority: `rst`, `tx_valid` and `bit_en` all high on the same edge.
  - Required: no accept, and all outputs at reset values.

Source files
------------

// File: rtl/tx_serializer.sv
// tx_serializer: parallel-to-serial framer for the H-bridge driver.
// Frame = preamble, data LSB-first, even parity; leg select fixed per frame.
module tx_serializer #(
  parameter int                 WIDTH       = 8,
  parameter int                 PRE_LEN     = 4,
  parameter logic [PRE_LEN-1:0] PRE_PATTERN = 4'b0101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_lane,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_bit,
  output logic             ser_sel,
  output logic             ser_active
);

  localparam int N  = PRE_LEN + WIDTH + 1;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] idx_q;
  logic [N-2:0]  shift_q;
  logic [N-1:0]  frame;
  logic          accept;
  logic          advance;
  logic          last;

  // Whole frame assembled at acceptance; bit 0 goes straight to the line.
  assign frame    = {^tx_data, tx_data, PRE_PATTERN};
  assign tx_ready = (state_q == IDLE) && !rst;

  // Next-state and datapath strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    advance = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bit_en) begin
          advance = 1'b1;
          if (idx_q == LAST) begin
            last    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Shift register, bit index and registered driver outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      shift_q    <= '0;
      ser_bit    <= 1'b0;
      ser_sel    <= 1'b0;
      ser_active <= 1'b0;
    end else if (accept) begin
      idx_q      <= '0;
      shift_q    <= frame[N-1:1];
      ser_bit    <= frame[0];
      ser_sel    <= tx_lane;
      ser_active <= 1'b1;
    end else if (last) begin
      idx_q      <= '0;
      ser_bit    <= 1'b0;
      ser_active <= 1'b0;
    end else if (advance) begin
      idx_q   <= idx_q + IW'(1);
      ser_bit <= shift_q[0];
      shift_q <= shift_q >> 1;
    end
  end

endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: directed checks of framing, strobing and reset.
// Expected frames are hand-built {parity, data, preamble} constants.
module tb_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_en = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_lane = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ser_bit;
  logic       ser_sel;
  logic       ser_active;

  int n_vec = 0;
  int n_err = 0;

  tx_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .tx_data   (tx_data),
    .tx_lane   (tx_lane),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ser_bit   (ser_bit),
    .ser_sel   (ser_sel),
    .ser_active(ser_active)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one word with bit_en=1, toggling tx_lane every cycle mid-frame.
  task automatic send_frame(input string tag, input logic [7:0] d,
                            input logic lane, input logic [12:0] exp);
    chk({tag, ".ready_pre"}, 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_lane  = lane;
    tx_valid = 1'b1;
    bit_en   = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~d;
    for (int j = 0; j < 13; j++) begin
      chk($sformatf("%s.bit%0d", tag, j), 32'(ser_bit), 32'(exp[j]));
      chk($sformatf("%s.act%0d", tag, j), 32'(ser_active), 32'd1);
      chk($sformatf("%s.sel%0d", tag, j), 32'(ser_sel), 32'(lane));
      chk($sformatf("%s.rdy%0d", tag, j), 32'(tx_ready), 32'd0);
      tx_lane = ~tx_lane;
      tick();
    end
    chk({tag, ".bit_end"}, 32'(ser_bit), 32'd0);
    chk({tag, ".act_end"}, 32'(ser_active), 32'd0);
    chk({tag, ".rdy_end"}, 32'(tx_ready), 32'd1);
    chk({tag, ".sel_end"}, 32'(ser_sel), 32'(lane));
  endtask

  localparam logic [12:0] F3C = 13'b0_00111100_0101;
  localparam logic [12:0] F01 = 13'b1_00000001_0101;
  localparam logic [12:0] FA5 = 13'b0_10100101_0101;
  localparam logic [12:0] F55 = 13'b0_01010101_0101;
  localparam logic [12:0] FAA = 13'b0_10101010_0101;

  initial begin
    int acc2;

    // Reset values.
    tick();
    tick();
    chk("rst.ready", 32'(tx_ready), 32'd0);
    chk("rst.bit", 32'(ser_bit), 32'd0);
    chk("rst.sel", 32'(ser_sel), 32'd0);
    chk("rst.act", 32'(ser_active), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready_rel", 32'(tx_ready), 32'd1);
    tick();

    // Basic frame and odd parity with lane 1.
    send_frame("basic", 8'h3C, 1'b0, F3C);
    tick();
    send_frame("odd", 8'h01, 1'b1, F01);
    tick();
    chk("odd.sel_hold", 32'(ser_sel), 32'd1);

    // Reset priority over simultaneous tx_valid and bit_en.
    rst      = 1'b1;
    tx_valid = 1'b1;
    bit_en   = 1'b1;
    tx_data  = 8'hFF;
    tx_lane  = 1'b1;
    tick();
    chk("prio.bit", 32'(ser_bit), 32'd0);
    chk("prio.sel", 32'(ser_sel), 32'd0);
    chk("prio.act", 32'(ser_active), 32'd0);
    chk("prio.ready", 32'(tx_ready), 32'd0);
    rst      = 1'b0;
    tx_valid = 1'b0;
    tick();
    chk("prio.act_after", 32'(ser_active), 32'd0);
    chk("prio.ready_after", 32'(tx_ready), 32'd1);

    // Baud strobe every 4th cycle; accept edge has bit_en low.
    tx_data  = 8'hA5;
    tx_lane  = 1'b0;
    tx_valid = 1'b1;
    bit_en   = 1'b0;
    tick();
    tx_valid = 1'b0;
    for (int j = 1; j <= 52; j++) begin
      chk($sformatf("baud.bit_c%0d", j), 32'(ser_bit),
          32'(FA5[(j - 1) / 4]));
      chk($sformatf("baud.act_c%0d", j), 32'(ser_active), 32'd1);
      bit_en = (j % 4 == 0);
      tick();
    end
    chk("baud.act_end", 32'(ser_active), 32'd0);
    chk("baud.bit_end", 32'(ser_bit), 32'd0);
    chk("baud.rdy_end", 32'(tx_ready), 32'd1);
    bit_en = 1'b0;
    tick();

    // Back-to-back with tx_valid held high.
    tx_data  = 8'h55;
    tx_lane  = 1'b0;
    tx_valid = 1'b1;
    bit_en   = 1'b1;
    chk("b2b.ready0", 32'(tx_ready), 32'd1);
    tick();
    tx_data = 8'hAA;
    tx_lane = 1'b1;
    acc2    = -1;
    for (int c = 1; c <= 20 && acc2 < 0; c++) begin
      if (tx_ready) begin
        acc2 = c;
      end else begin
        chk($sformatf("b2b.f1_bit%0d", c - 1), 32'(ser_bit),
            32'(F55[c - 1]));
        chk($sformatf("b2b.f1_sel%0d", c - 1), 32'(ser_sel), 32'd0);
        tick();
      end
    end
    chk("b2b.spacing", 32'(acc2), 32'd14);
    tick();
    tx_valid = 1'b0;
    for (int j = 0; j < 13; j++) begin
      chk($sformatf("b2b.f2_bit%0d", j), 32'(ser_bit), 32'(FAA[j]));
      chk($sformatf("b2b.f2_sel%0d", j), 32'(ser_sel), 32'd1);
      chk($sformatf("b2b.f2_rdy%0d", j), 32'(tx_ready), 32'd0);
      tx_lane = ~tx_lane;
      tick();
    end
    chk("b2b.rdy_end", 32'(tx_ready), 32'd1);
    tick();

    // Reset mid-frame at bit index 6.
    tx_data  = 8'h3C;
    tx_lane  = 1'b1;
    tx_valid = 1'b1;
    bit_en   = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    chk("mid.bit6", 32'(ser_bit), 32'(F3C[6]));
    chk("mid.sel6", 32'(ser_sel), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid.bit", 32'(ser_bit), 32'd0);
    chk("mid.sel", 32'(ser_sel), 32'd0);
    chk("mid.act", 32'(ser_active), 32'd0);
    chk("mid.ready_rst", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid.ready_rel", 32'(tx_ready), 32'd1);
    send_frame("mid.restart", 8'h01, 1'b0, F01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
